// File: rtl/wb_stage_if.sv
// Memory-stage to write-back handoff: valid/ready handshake plus the completed-instruction payload.
interface wb_stage_if;
   logic        inValid;
   logic        inReady;
   logic        inRegWrite;
   logic        inMemToReg;
   logic [1:0]  inLoadSize;
   logic        inLoadSigned;
   logic [1:0]  inByteOffset;
   logic [31:0] inAluResult;
   logic [31:0] inMemData;
   logic [4:0]  inDestReg;

   modport master (
      output inValid, inRegWrite, inMemToReg, inLoadSize, inLoadSigned,
             inByteOffset, inAluResult, inMemData, inDestReg,
      input  inReady
   );

   modport slave (
      input  inValid, inRegWrite, inMemToReg, inLoadSize, inLoadSigned,
             inByteOffset, inAluResult, inMemData, inDestReg,
      output inReady
   );
endinterface

// File: rtl/wb_stage.sv
// MIPS write-back stage: formats load/ALU results into a 2-entry skid FIFO and retires one register write per cycle.
// Optional macro WB_FORWARD_EN adds fwdValid/fwdReg/fwdData describing the youngest buffered register write.
module wb_stage #(
   parameter int unsigned CNT_W         = 32,
   parameter bit          ZERO_SUPPRESS = 1'b1
) (
   input  logic             clk,
   input  logic             resetN,
   wb_stage_if.slave        inBus,
   input  logic             wbHold,
   output logic             regWrite,
   output logic [4:0]       writeRegister,
   output logic [31:0]      writeData,
   output logic [CNT_W-1:0] retireCount,
   output logic             empty
`ifdef WB_FORWARD_EN
   ,
   output logic             fwdValid,
   output logic [4:0]       fwdReg,
   output logic [31:0]      fwdData
`endif
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;

   typedef struct packed {
      logic              wr;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t     entries [2];
   entry_t     newEntry;
   entry_t     headEntry;
   logic [1:0] count;
   logic       headPtr;
   logic       tailPtr;
   logic       push;
   logic       pop;
   logic [7:0]        loadByte;
   logic [15:0]       loadHalf;
   logic [DATA_W-1:0] loadVal;

   // Lane select and extension of the incoming result, so only formatted data is buffered
   always_comb begin
      loadByte = 8'(inBus.inMemData >> {inBus.inByteOffset, 3'b000});
      loadHalf = inBus.inByteOffset[1] ? inBus.inMemData[31:16] : inBus.inMemData[15:0];
      case (inBus.inLoadSize)
         2'b01:   loadVal = {{16{inBus.inLoadSigned & loadHalf[15]}}, loadHalf};
         2'b10:   loadVal = {{24{inBus.inLoadSigned & loadByte[7]}}, loadByte};
         default: loadVal = inBus.inMemData;
      endcase
      newEntry.wr   = inBus.inRegWrite;
      newEntry.dest = inBus.inDestReg;
      newEntry.data = inBus.inMemToReg ? loadVal : inBus.inAluResult;
   end

   assign inBus.inReady = resetN & (count < 2'd2);
   assign push          = inBus.inValid & inBus.inReady;
   assign pop           = (count != 2'd0) & ~wbHold;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         count       <= 2'd0;
         headPtr     <= 1'b0;
         tailPtr     <= 1'b0;
         retireCount <= '0;
         for (int i = 0; i < 2; i++) entries[i] <= '0;
      end else begin
         if (push) begin
            entries[tailPtr] <= newEntry;
            tailPtr          <= ~tailPtr;
         end
         if (pop) begin
            headPtr     <= ~headPtr;
            retireCount <= retireCount + CNT_W'(1);
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

   // Head drive; dest 0 writes still retire but never reach the register file when suppressed
   always_comb begin
      headEntry     = entries[headPtr];
      empty         = (count == 2'd0);
      writeRegister = empty ? '0 : headEntry.dest;
      writeData     = empty ? '0 : headEntry.data;
      regWrite      = ~empty & headEntry.wr & ~wbHold &
                      ~(ZERO_SUPPRESS & (headEntry.dest == '0));
   end

`ifdef WB_FORWARD_EN
   entry_t youngEntry;
   entry_t oldEntry;

   // Youngest entry sits just behind the tail; the older one is only live when full
   always_comb begin
      youngEntry = entries[~tailPtr];
      oldEntry   = entries[tailPtr];
      fwdValid   = 1'b0;
      fwdReg     = '0;
      fwdData    = '0;
      if ((count != 2'd0) && youngEntry.wr && (youngEntry.dest != '0)) begin
         fwdValid = 1'b1;
         fwdReg   = youngEntry.dest;
         fwdData  = youngEntry.data;
      end else if ((count == 2'd2) && oldEntry.wr && (oldEntry.dest != '0)) begin
         fwdValid = 1'b1;
         fwdReg   = oldEntry.dest;
         fwdData  = oldEntry.data;
      end
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver queues expected retirements on accept, negedge monitor checks the head.
// Define WB_FORWARD_EN to also check the forwarding outputs.
module tb_wb_stage;
   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        wbHold = 1'b0;
   logic        regWrite;
   logic [4:0]  writeRegister;
   logic [31:0] writeData;
   logic [31:0] retireCount;
   logic        empty;
`ifdef WB_FORWARD_EN
   logic        fwdValid;
   logic [4:0]  fwdReg;
   logic [31:0] fwdData;
`endif

   always #5 clk = ~clk;

   wb_stage_if bus ();

   wb_stage #(.CNT_W(32), .ZERO_SUPPRESS(1'b1)) dut (
      .clk           (clk),
      .resetN        (resetN),
      .inBus         (bus),
      .wbHold        (wbHold),
      .regWrite      (regWrite),
      .writeRegister (writeRegister),
      .writeData     (writeData),
      .retireCount   (retireCount),
      .empty         (empty)
`ifdef WB_FORWARD_EN
      ,
      .fwdValid      (fwdValid),
      .fwdReg        (fwdReg),
      .fwdData       (fwdData)
`endif
   );

   typedef struct {
      bit        wr;
      bit [4:0]  dest;
      bit [31:0] data;
   } exp_t;

   exp_t        q[$];
   int          nChecks = 0;
   int          nFails  = 0;
   bit [31:0]   retModel = 0;
   bit          randHold = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (randHold) begin
      #1 wbHold = ($urandom_range(0, 3) == 0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference formatting from the lane rules, using plain shifts and arithmetic
   function automatic bit [31:0] fmt(bit m2r, bit [1:0] size, bit sg, bit [1:0] off,
                                     bit [31:0] alu, bit [31:0] mem);
      bit [31:0] v;
      if (!m2r) return alu;
      case (size)
         2'b10: begin
            v = (mem >> (8 * off)) & 32'hFF;
            if (sg && v >= 32'h80) v = v - 32'h100;
         end
         2'b01: begin
            v = (mem >> (16 * off[1])) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v - 32'h10000;
         end
         default: v = mem;
      endcase
      return v;
   endfunction

   task automatic send(input bit wr, input bit m2r, input bit [1:0] size, input bit sg,
                       input bit [1:0] off, input bit [31:0] alu, input bit [31:0] mem,
                       input bit [4:0] dest);
      bit acc = 0;
      int n = 0;
      exp_t e;
      bus.inValid = 1'b1;     bus.inRegWrite = wr;    bus.inMemToReg = m2r;
      bus.inLoadSize = size;  bus.inLoadSigned = sg;  bus.inByteOffset = off;
      bus.inAluResult = alu;  bus.inMemData = mem;    bus.inDestReg = dest;
      while (!acc && n < 64) begin
         @(negedge clk);
         acc = bus.inReady;
         @(posedge clk);
         if (acc) begin
            e.wr = wr; e.dest = dest; e.data = fmt(m2r, size, sg, off, alu, mem);
            q.push_back(e);
         end
         #1;
         n++;
      end
      bus.inValid = 1'b0;
      if (!acc) begin
         nChecks++;
         nFails++;
         $display("FAIL send_timeout: got no accept expected accept within 64 cycles");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: compares head outputs against the oldest expected entry, retiring it when not held
   always @(negedge clk) begin : mon
      exp_t e;
      bit   fv;
      exp_t fe;
      if (!resetN) begin
         q.delete();
         retModel = 0;
         chk("rst_regWrite", regWrite, 0);
         chk("rst_writeRegister", writeRegister, 0);
         chk("rst_writeData", writeData, 0);
         chk("rst_retireCount", retireCount, 0);
         chk("rst_empty", empty, 1);
         chk("rst_inReady", bus.inReady, 0);
`ifdef WB_FORWARD_EN
         chk("rst_fwdValid", fwdValid, 0);
`endif
      end else begin
         chk("empty", empty, q.size() == 0);
         chk("inReady", bus.inReady, q.size() < 2);
         chk("retireCount", retireCount, retModel);
`ifdef WB_FORWARD_EN
         fv = 0;
         fe.wr = 0; fe.dest = 0; fe.data = 0;
         for (int i = q.size() - 1; i >= 0; i--)
            if (!fv && q[i].wr && q[i].dest != 0) begin
               fv = 1;
               fe = q[i];
            end
         chk("fwdValid", fwdValid, fv);
         chk("fwdReg", fwdReg, fe.dest);
         chk("fwdData", fwdData, fe.data);
`endif
         if (q.size() == 0) begin
            chk("idle_regWrite", regWrite, 0);
            chk("idle_writeRegister", writeRegister, 0);
            chk("idle_writeData", writeData, 0);
         end else begin
            e = q[0];
            chk("writeRegister", writeRegister, e.dest);
            chk("writeData", writeData, e.data);
            chk("regWrite", regWrite, e.wr && e.dest != 0 && !wbHold);
            if (!wbHold) begin
               void'(q.pop_front());
               retModel = retModel + 1;
            end
         end
      end
   end

   initial begin
      int start;
      int n;
      bus.inValid = 0;     bus.inRegWrite = 0;  bus.inMemToReg = 0;
      bus.inLoadSize = 0;  bus.inLoadSigned = 0; bus.inByteOffset = 0;
      bus.inAluResult = 0; bus.inMemData = 0;   bus.inDestReg = 0;
      idle(3);
      resetN = 1'b1;
      idle(1);

      // ALU write and sub-word loads
      send(1, 0, 2'b00, 0, 2'd0, 32'h0000_002A, 32'h0, 5'd5);
      idle(3);
      send(1, 1, 2'b10, 1, 2'd1, 32'h0, 32'h1234_80FF, 5'd8);
      send(1, 1, 2'b01, 0, 2'd2, 32'h0, 32'h1234_80FF, 5'd9);
      idle(3);

      // Hold fills the buffer, then release drains in order
      wbHold = 1'b1;
      send(1, 0, 2'b00, 0, 2'd0, 32'h0000_0333, 32'h0, 5'd3);
      send(1, 0, 2'b00, 0, 2'd0, 32'h0000_0444, 32'h0, 5'd4);
      @(negedge clk);
      chk("hold_full_inReady", bus.inReady, 0);
      chk("hold_regWrite", regWrite, 0);
      @(posedge clk);
      #1 wbHold = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("release_inReady", bus.inReady, 1);
      idle(1);
      send(1, 0, 2'b00, 0, 2'd0, 32'h0000_0555, 32'h0, 5'd6);
      idle(3);

      // Destination 0 retires without a write
      send(1, 0, 2'b00, 0, 2'd0, 32'hDEAD_BEEF, 32'h0, 5'd0);
      idle(3);

      // Back-to-back: one accept per cycle
      start = cyc;
      for (int i = 0; i < 10; i++)
         send(1, 0, 2'b00, 0, 2'd0, $urandom, 32'h0, 5'(i + 1));
      chk("b2b_cycles", cyc - start, 10);
      idle(3);

      // Reset with two buffered entries discards them
      wbHold = 1'b1;
      send(1, 0, 2'b00, 0, 2'd0, 32'h1111_1111, 32'h0, 5'd10);
      send(1, 0, 2'b00, 0, 2'd0, 32'h2222_2222, 32'h0, 5'd11);
      resetN = 1'b0;
      idle(2);
      resetN = 1'b1;
      wbHold = 1'b0;
      idle(4);

      // Randomized traffic with random hold
      randHold = 1;
      for (int i = 0; i < 200; i++) begin
         send($urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom), 1'($urandom),
              2'($urandom), $urandom, $urandom, 5'($urandom));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      randHold = 0;
      @(posedge clk);
      #2 wbHold = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      nChecks++;
      if (q.size() != 0) begin
         nFails++;
         $display("FAIL drain: got %0d entries left expected 0", q.size());
      end
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
